// File: rtl/down_timer.sv
// ---------------------------------------------------------------------------
// down_timer -- loadable down-counting interval timer
//
// Loads a preset, counts it down on enabled cycles and emits a one-cycle
// terminal-count pulse (tc) on expiry. The timer either stops in EXPIRED
// (one-shot) or restarts from the reload register (auto-reload).
//
// Optional build macro:
//   DOWN_TIMER_PRESCALE_EN -- adds a prescaler so that each decrement takes
//                             PRESCALE enabled RUN cycles. When the macro is
//                             undefined there is no prescale logic and
//                             PRESCALE has no effect.
//
// Parameters:
//   WIDTH    -- width of data and count
//   PRESCALE -- enabled cycles per decrement (prescale build only, 2..256)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   enable      in   count-enable qualifier (RUN state only)
//   load        in   synchronous load of data into count and reload register
//   data        in   preset value
//   auto_reload in   1 = restart from reload value on expiry, 0 = one-shot
//   count       out  current count (registered)
//   tc          out  terminal-count pulse (registered)
//   busy        out  state is RUN
//   expired     out  state is EXPIRED
// ---------------------------------------------------------------------------
module down_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             expired
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;

  // tick marks the enabled RUN cycle on which the count actually moves.
  logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int unsigned PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] psc_q;

  // The count moves only when the prescaler is about to wrap.
  assign tick = (psc_q == PS_LAST);
`else
  // Without the prescaler every enabled RUN cycle is a tick.
  assign tick = 1'b1;

  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
`endif

  // Single-block FSM: state, count, reload value and the tc pulse all update
  // together so the outputs are registered and mutually consistent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
      psc_q    <= '0;
`endif
    end else if (load) begin
      // Load wins over everything, including an expiry on the same edge,
      // so no tc is ever produced on a load edge.
      count_q  <= data;
      reload_q <= data;
      tc_q     <= 1'b0;
      state_q  <= (data != '0) ? S_RUN : S_IDLE;
`ifdef DOWN_TIMER_PRESCALE_EN
      psc_q    <= '0;
`endif
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (enable) begin
`ifdef DOWN_TIMER_PRESCALE_EN
            psc_q <= tick ? '0 : psc_q + 1'b1;
`endif
            if (tick) begin
              // count is never 0 in RUN (zero loads go to IDLE and
              // expiry leaves RUN or reloads a non-zero value).
              if (count_q > WIDTH'(1)) begin
                count_q <= count_q - 1'b1;
              end else begin
                tc_q <= 1'b1;
                if (auto_reload) begin
                  count_q <= reload_q;
                end else begin
                  count_q <= '0;
                  state_q <= S_EXPIRED;
`ifdef DOWN_TIMER_PRESCALE_EN
                  psc_q   <= '0;
`endif
                end
              end
            end
          end
        end
        // IDLE and EXPIRED hold until the next load.
        S_IDLE, S_EXPIRED: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign busy    = (state_q == S_RUN);
  assign expired = (state_q == S_EXPIRED);

  // A running timer always has something left to count.
  a_run_nonzero : assert property (@(posedge clk) disable iff (!reset)
    busy |-> (count != '0));

  // A one-shot that has finished always reads zero.
  a_expired_zero : assert property (@(posedge clk) disable iff (!reset)
    expired |-> (count == '0));

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

  localparam int W   = 8;
  localparam int PRE = 4;
`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int PS = PRE;
`else
  localparam int PS = 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] data = '0;
  logic [W-1:0] count;
  logic         tc, busy, expired;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(W), .PRESCALE(PRE)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .data(data),
    .auto_reload(auto_reload), .count(count), .tc(tc), .busy(busy),
    .expired(expired)
  );

  // Behavioural model: remaining ticks, a sub-tick counter and a mode
  // (0 idle, 1 running, 2 finished).
  int m_cnt = 0, m_rel = 0, m_mode = 0, m_sub = 0;
  bit m_tc = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_rel = 0; m_mode = 0; m_sub = 0; m_tc = 1'b0;
    end else begin
      m_tc = 1'b0;
      if (load) begin
        m_cnt = int'(data); m_rel = int'(data); m_sub = 0;
        m_mode = (data != 0) ? 1 : 0;
      end else if (m_mode == 1 && enable) begin
        m_sub = m_sub + 1;
        if (m_sub == PS) begin
          m_sub = 0;
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_tc = 1'b1;
            if (auto_reload) m_cnt = m_rel;
            else m_mode = 2;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [W+2:0] act, exp;
    act = {count, tc, busy, expired};
    exp = {m_cnt[W-1:0], m_tc, (m_mode == 1), (m_mode == 2)};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model t=%0t count/tc/busy/expired got %h/%b/%b/%b want %h/%b/%b/%b",
               $time, count, tc, busy, expired, m_cnt[W-1:0], m_tc,
               (m_mode == 1), (m_mode == 2));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; data = v;
    tick(1);
    load = 1'b0;
  endtask

  int exp_seq[6] = '{2, 1, 3, 2, 1, 3};

  initial begin
    // Power-on reset
    tick(2);
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", {tc, busy, expired}, 0);
    reset = 1'b1;

    // 1. Asynchronous reset mid-run
    do_load(8'h37);
    chk("t1_loaded", 32'(count), 32'h37);
    chk("t1_busy", 32'(busy), 1);
    tick(2);
    #2 reset = 1'b0;
    #1;
    chk("t1_async_count", 32'(count), 0);
    chk("t1_async_flags", {tc, busy, expired}, 0);
    tick(1);
    reset = 1'b1;
    enable = 1'b1;
    tick(3);
    chk("t1_hold0", 32'(count), 0);
    chk("t1_idle", {tc, busy, expired}, 0);

    // 2. One-shot
    auto_reload = 1'b0;
    do_load(8'd5);
    chk("t2_load", 32'(count), 5);
    for (int k = 4; k >= 0; k--) begin
      tick(PS);
      chk("t2_count", 32'(count), 32'(k));
      chk("t2_tc", 32'(tc), (k == 0) ? 1 : 0);
    end
    chk("t2_state", {busy, expired}, 2'b01);
    tick(10);
    chk("t2_after", {count, tc, busy, expired}, {8'd0, 3'b001});

    // 3. Auto-reload
    auto_reload = 1'b1;
    do_load(8'd3);
    chk("t3_load", 32'(count), 3);
    for (int i = 0; i < 6; i++) begin
      tick(PS);
      chk("t3_count", 32'(count), 32'(exp_seq[i]));
      chk("t3_tc", 32'(tc), (exp_seq[i] == 3) ? 1 : 0);
      chk("t3_busy", 32'(busy), 1);
    end
    // auto_reload may change mid-run; it is only looked at on expiry
    auto_reload = 1'b0;
    tick(3 * PS);
    chk("t3_to_oneshot", {count, tc, busy, expired}, {8'd0, 3'b101});

    // 4. Hold and load priority
    auto_reload = 1'b0;
    do_load(8'hA5);
    tick(3 * PS);
    chk("t4_a2", 32'(count), 32'hA2);
    enable = 1'b0;
    tick(3);
    chk("t4_hold", 32'(count), 32'hA2);
    enable = 1'b1;
    tick((8'hA2 - 1) * PS);
    chk("t4_at1", 32'(count), 1);
    if (PS > 1) tick(PS - 1);
    do_load(8'h02);
    chk("t4_reload", {count, tc, busy, expired}, {8'd2, 3'b010});

    // 5. Zero load
    do_load(8'h00);
    chk("t5_zero", {count, tc, busy, expired}, {8'd0, 3'b000});
    tick(4);
    chk("t5_stay", {count, tc, busy, expired}, {8'd0, 3'b000});

`ifdef DOWN_TIMER_PRESCALE_EN
    // 6. Prescaled one-shot with an enable gap
    auto_reload = 1'b0;
    do_load(8'd2);
    tick(3);
    chk("t6_still2", 32'(count), 2);
    tick(1);
    chk("t6_now1", 32'(count), 1);
    tick(2);
    enable = 1'b0;
    tick(2);
    chk("t6_gap", {count, tc}, {8'd1, 1'b0});
    enable = 1'b1;
    tick(1);
    chk("t6_pre", {count, tc}, {8'd1, 1'b0});
    tick(1);
    chk("t6_tc", {count, tc, busy, expired}, {8'd0, 3'b101});
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
